// File: rtl/code2421_deserializer.sv
// code2421_deserializer: decodes a stream of 2421 (Aiken) digits to BCD and packs them into words.
module code2421_deserializer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          in_code_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4*DIGITS-1:0] out_bcd_o,
  output logic [2:0]          out_ndig_o,
  output logic                out_err_o
);
  localparam int AW = 4 * DIGITS;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t         state_q;
  logic [AW-1:0]  acc_q, acc_d, out_bcd_q;
  logic [2:0]     cnt_q, cnt_d, out_ndig_q;
  logic           err_q, err_d, out_err_q;
  logic           inv, close;
  logic [3:0]     dig;
  always_comb begin
    inv   = (in_code_i >= 4'd5) && (in_code_i <= 4'd10);
    // codes 1011..1111 sit 6 above their decimal value
    dig   = inv ? 4'd0 : in_code_i[3] ? in_code_i - 4'd6 : in_code_i;
    acc_d = (acc_q << 4) | AW'(dig);
    cnt_d = cnt_q + 3'd1;
    err_d = err_q | inv;
    close = in_last_i || (cnt_d == 3'(DIGITS));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      out_bcd_q  <= '0;
      out_ndig_q <= '0;
      out_err_q  <= 1'b0;
    end else if (state_q == COLLECT && in_valid_i) begin
      if (close) begin
        state_q    <= HOLD;
        out_bcd_q  <= acc_d;
        out_ndig_q <= cnt_d;
        out_err_q  <= err_d;
        acc_q      <= '0;
        cnt_q      <= '0;
        err_q      <= 1'b0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end else if (state_q == HOLD && out_ready_i) begin
      state_q <= COLLECT;
    end
  end
  assign in_ready_o  = (state_q == COLLECT);
  assign out_valid_o = (state_q == HOLD);
  assign out_bcd_o   = out_bcd_q;
  assign out_ndig_o  = out_ndig_q;
  assign out_err_o   = out_err_q;
endmodule

// File: tb/tb_code2421_deserializer.sv
// tb_code2421_deserializer: directed self-checking bench for the 2421 deserializer (DIGITS=4).
module tb_code2421_deserializer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [3:0]  in_code = 4'd0;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_bcd;
  logic [2:0]  out_ndig;
  int          n_cmp = 0, n_bad = 0;
  logic [3:0]  tab [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0,
                            4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  code2421_deserializer #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_code_i(in_code), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_bcd_o(out_bcd), .out_ndig_o(out_ndig), .out_err_o(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] c, input logic l);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_code  = c;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic word(input string tag, input logic [15:0] b, input logic [2:0] n, input logic e);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_bcd"}, out_bcd, b);
    chk({tag, "_ndig"}, out_ndig, n);
    chk({tag, "_err"}, out_err, e);
  endtask
  initial begin
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bcd", out_bcd, 16'h0);
    chk("rst_ndig", out_ndig, 3'd0);
    chk("rst_err", out_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    // full word, back to back, no backpressure
    send(4'b1011, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b1110, 1'b0);
    word("full", 16'h5928, 3'd4, 1'b0);
    chk("full_inrdy_low", in_ready, 1'b0);
    tick();
    chk("full_valid_drop", out_valid, 1'b0);
    chk("full_inrdy_back", in_ready, 1'b1);
    // every code as a single-digit word
    for (int c = 0; c < 16; c++) begin
      send(4'(c), 1'b1);
      word($sformatf("single%0d", c), {12'h0, tab[c]}, 3'd1, (c >= 5 && c <= 10));
    end
    // short word
    send(4'b1101, 1'b0);
    send(4'b0001, 1'b1);
    word("short", 16'h0071, 3'd2, 1'b0);
    // error sticky within a word only
    send(4'b0000, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    word("errA", 16'h0034, 3'd4, 1'b1);
    send(4'b1100, 1'b1);
    word("errB", 16'h0006, 3'd1, 1'b0);
    // backpressure with upstream still pushing
    tick();
    out_ready = 1'b0;
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = 4'(15 - i);
      in_last  = i[0];
      tick();
      word($sformatf("bp%0d", i), 16'h1234, 3'd4, 1'b0);
      chk($sformatf("bp%0d_inrdy", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_release", out_valid, 1'b0);
    send(4'b1011, 1'b1);
    word("bp_next", 16'h0005, 3'd1, 1'b0);
    // reset mid-word
    send(4'b1110, 1'b0);
    send(4'b1111, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    send(4'b0011, 1'b0);
    send(4'b0010, 1'b1);
    word("rst_mid", 16'h0032, 3'd2, 1'b0);
    // reset during HOLD clears outputs without a clock edge
    tick();
    out_ready = 1'b0;
    send(4'b0001, 1'b1);
    word("hold", 16'h0001, 3'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("hrst_valid", out_valid, 1'b0);
    chk("hrst_ready", in_ready, 1'b1);
    chk("hrst_bcd", out_bcd, 16'h0);
    chk("hrst_ndig", out_ndig, 3'd0);
    chk("hrst_err", out_err, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hrst_quiet%0d", i), out_valid, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
